// File: rtl/hazard_unit_if.sv
// hazard_unit_if: control bundle between the five-stage datapath and hazard_unit.
// The datapath side is the master; hazard_unit consumes it through the slave modport.
interface hazard_unit_if #(parameter int REGADDR = 5);
  logic                ihit;
  logic                dhit;
  logic [REGADDR-1:0]  ifid_rs;
  logic [REGADDR-1:0]  ifid_rt;
  logic                ifid_uses_rt;
  logic                idex_memread;
  logic [REGADDR-1:0]  idex_dest;
  logic                exmem_dmemren;
  logic                exmem_dmemwen;
  logic                ex_redirect;
  logic                exmem_halt;
  logic                pc_en;
  logic                ifid_en;
  logic                idex_en;
  logic                exmem_en;
  logic                memwb_en;
  logic                ifid_flush;
  logic                idex_flush;
  logic                halted;
  logic [31:0]         stall_cycles;
  logic [31:0]         flush_count;

  modport master (
    output ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_dest,
           exmem_dmemren, exmem_dmemwen, ex_redirect, exmem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, stall_cycles, flush_count
  );

  modport slave (
    input  ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_dest,
           exmem_dmemren, exmem_dmemwen, ex_redirect, exmem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: latch enables, flushes and PC enable for the five-stage pipeline.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
//
// state   | meaning
// RUN     | normal issue, priority rules evaluated every cycle
// MEMWAIT | data access outstanding, pipeline frozen until dhit
// LOADBUB | load-use bubble just inserted, load-use check suppressed
// HALTED  | halt reached MEM, parked until reset
module hazard_unit #(
  parameter int REGADDR = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  hazard_unit_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEMWAIT, LOADBUB, HALTED} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [REGADDR-1:0] dest;
  logic               memop;
  logic               loaduse;
  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               exmem_en;
  logic               memwb_en;
  logic               ifid_flush;
  logic               idex_flush;

  assign dest    = bus.idex_dest;
  assign memop   = bus.exmem_dmemren | bus.exmem_dmemwen;
  assign loaduse = bus.idex_memread && (dest != '0) &&
                   ((dest == bus.ifid_rs) || (bus.ifid_uses_rt && (dest == bus.ifid_rt)));

  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!nRST) begin
      state_nxt = RUN;
    end else begin
      case (state)
        HALTED: state_nxt = HALTED;
        default: begin
          // MEMWAIT with dhit and LOADBUB both fall through to the RUN priority chain.
          if ((state == MEMWAIT) && !bus.dhit) begin
            state_nxt = MEMWAIT;
          end else if (bus.exmem_halt) begin
            state_nxt = HALTED;
          end else if (memop && !bus.dhit) begin
            state_nxt = MEMWAIT;
          end else if (bus.ex_redirect) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
          end else if (loaduse && (state != LOADBUB)) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_flush = 1'b1;
            state_nxt  = LOADBUB;
          end else if (!bus.ihit) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            ifid_flush = 1'b1;
            state_nxt  = RUN;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            state_nxt = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.idex_en    = idex_en;
  assign bus.exmem_en   = exmem_en;
  assign bus.memwb_en   = memwb_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.halted     = (state == HALTED);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (state != HALTED) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if ((ifid_flush || idex_flush) && (flush_q != '1)) flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed stimulus against a rule-level model of hazard_unit,
// with per-cycle comparison plus hand-computed literal expectations.
module tb_hazard_unit;

  logic CLK = 1'b0;
  logic nRST;

  hazard_unit_if #(.REGADDR(5)) hif ();

  hazard_unit #(.REGADDR(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (hif)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: what the pipeline is doing this cycle, decided straight from the rules.
  typedef enum {A_RESET, A_PARKED, A_HALT, A_FREEZE, A_REDIRECT, A_BUBBLE,
                A_FETCHMISS, A_FLOW} act_t;

  bit     m_parked, m_waiting, m_bubble_done;
  longint m_stalls, m_flushes;

  function automatic bit hazard();
    if (!hif.idex_memread || hif.idex_dest == 0) return 0;
    if (hif.idex_dest == hif.ifid_rs) return 1;
    return hif.ifid_uses_rt && (hif.idex_dest == hif.ifid_rt);
  endfunction

  function automatic act_t action();
    if (!nRST) return A_RESET;
    if (m_parked) return A_PARKED;
    if (m_waiting && !hif.dhit) return A_FREEZE;
    if (hif.exmem_halt) return A_HALT;
    if ((hif.exmem_dmemren || hif.exmem_dmemwen) && !hif.dhit) return A_FREEZE;
    if (hif.ex_redirect) return A_REDIRECT;
    if (!m_bubble_done && hazard()) return A_BUBBLE;
    if (!hif.ihit) return A_FETCHMISS;
    return A_FLOW;
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted}
  function automatic logic [7:0] vec(input act_t a);
    case (a)
      A_PARKED:    return 8'b0000_0001;
      A_REDIRECT:  return 8'b1111_1110;
      A_BUBBLE:    return 8'b0011_1010;
      A_FETCHMISS: return 8'b0111_1100;
      A_FLOW:      return 8'b1111_1000;
      default:     return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] dut_vec();
    return {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
            hif.ifid_flush, hif.idex_flush, hif.halted};
  endfunction

  function automatic logic [31:0] exp_cnt(input longint c);
`ifdef HAZARD_PERF_EN
    return (c > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : c[31:0];
`else
    return (c < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_parked = 0; m_waiting = 0; m_bubble_done = 0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      act_t a;
      logic [7:0] v;
      a = action();
      v = vec(a);
      if (!v[7] && !m_parked) m_stalls++;
      if (v[2] || v[1]) m_flushes++;
      if (a == A_HALT) m_parked = 1;
      m_waiting     = (a == A_FREEZE);
      m_bubble_done = (a == A_BUBBLE);
    end
  end

  always @(negedge CLK) begin
    chk("ctl", {24'd0, dut_vec()}, {24'd0, vec(action())});
    chk("stall_cycles", hif.stall_cycles, exp_cnt(m_stalls));
    chk("flush_count", hif.flush_count, exp_cnt(m_flushes));
  end

  task automatic idle();
    hif.ihit = 1; hif.dhit = 0; hif.ifid_rs = 5'd1; hif.ifid_rt = 5'd2;
    hif.ifid_uses_rt = 0; hif.idex_memread = 0; hif.idex_dest = 5'd0;
    hif.exmem_dmemren = 0; hif.exmem_dmemwen = 0; hif.ex_redirect = 0;
    hif.exmem_halt = 0;
  endtask

  task automatic next();
    @(posedge CLK); #1;
  endtask

  initial begin
    nRST = 0;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ctl", {24'd0, dut_vec()}, 32'h00);
    chk("reset_stall", hif.stall_cycles, 32'd0);
    nRST = 1;
    #2 chk("flow_ctl", {24'd0, dut_vec()}, 32'hF8);

    // Memory wait: three frozen cycles, released by dhit.
    next(); hif.exmem_dmemren = 1; hif.dhit = 0;
    #2 chk("mw1", {24'd0, dut_vec()}, 32'h00);
    next(); #2 chk("mw2", {24'd0, dut_vec()}, 32'h00);
    next(); #2 chk("mw3", {24'd0, dut_vec()}, 32'h00);
    next(); hif.dhit = 1;
    #2 chk("mw_release", {24'd0, dut_vec()}, 32'hF8);
`ifdef HAZARD_PERF_EN
    chk("mw_stalls", hif.stall_cycles, 32'd3);
`endif
    next(); idle(); hif.exmem_dmemwen = 1; hif.dhit = 1;
    #2 chk("mw_same_cycle_hit", {24'd0, dut_vec()}, 32'hF8);

    // Redirect beats a fetch miss.
    next(); idle(); hif.ex_redirect = 1; hif.ihit = 0;
    #2 chk("redirect", {24'd0, dut_vec()}, 32'hFE);
    next(); idle();
    #2 chk("post_redirect", {24'd0, dut_vec()}, 32'hF8);
`ifdef HAZARD_PERF_EN
    chk("redirect_flushes", hif.flush_count, 32'd1);
`endif

    // Load-use through rs: one bubble, then flow with the same decode inputs.
    next(); hif.idex_memread = 1; hif.idex_dest = 5'd5; hif.ifid_rs = 5'd5;
    #2 chk("lu_bubble", {24'd0, dut_vec()}, 32'h3A);
    next(); #2 chk("lu_after", {24'd0, dut_vec()}, 32'hF8);
    next(); hif.idex_dest = 5'd0; hif.ifid_rs = 5'd0;
    #2 chk("lu_r0", {24'd0, dut_vec()}, 32'hF8);
    next(); hif.idex_dest = 5'd7; hif.ifid_rs = 5'd1; hif.ifid_rt = 5'd7; hif.ifid_uses_rt = 1;
    #2 chk("lu_rt", {24'd0, dut_vec()}, 32'h3A);
    next(); #2 chk("lu_rt_after", {24'd0, dut_vec()}, 32'hF8);
    next(); hif.ifid_uses_rt = 0;
    #2 chk("lu_rt_unused", {24'd0, dut_vec()}, 32'hF8);

    // Fetch miss for two cycles.
    next(); idle(); hif.ihit = 0;
    #2 chk("fm1", {24'd0, dut_vec()}, 32'h7C);
    next(); #2 chk("fm2", {24'd0, dut_vec()}, 32'h7C);

    // Halt raised during a memory wait is taken on the dhit cycle.
    next(); idle(); hif.exmem_dmemren = 1; hif.dhit = 0;
    next(); hif.exmem_halt = 1;
    #2 chk("mw_halt_wait", {24'd0, dut_vec()}, 32'h00);
    next(); hif.dhit = 1;
    #2 chk("mw_halt_take", {24'd0, dut_vec()}, 32'h00);
    next(); idle();
    #2 chk("parked1", {24'd0, dut_vec()}, 32'h01);
    repeat (3) next();
    #2 chk("parked2", {24'd0, dut_vec()}, 32'h01);
    nRST = 0;
    #1 chk("rst_halted", {24'd0, dut_vec()}, 32'h00);
    chk("rst_stall", hif.stall_cycles, 32'd0);
    chk("rst_flush", hif.flush_count, 32'd0);

    // Direct halt, then asynchronous reset mid-cycle.
    next(); nRST = 1; idle();
    #2 chk("resume", {24'd0, dut_vec()}, 32'hF8);
    next(); hif.exmem_halt = 1;
    #2 chk("halt_take", {24'd0, dut_vec()}, 32'h00);
    next(); hif.exmem_halt = 0;
    #2 chk("halted_a", {24'd0, dut_vec()}, 32'h01);
    next(); #2 chk("halted_b", {24'd0, dut_vec()}, 32'h01);
    nRST = 0;
    #1 chk("rst2_halted", {24'd0, dut_vec()}, 32'h00);
    chk("rst2_stall", hif.stall_cycles, 32'd0);
    chk("rst2_flush", hif.flush_count, 32'd0);
    next(); nRST = 1;
    next(); #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
